oam_dma_bus: RTL and testbench

- Sits directly downstream of the CPU's system-bus port. Routes CPU accesses to the external bus (cartridge/WRAM/IO) or to OAM.
- Owns the DMG OAM DMA engine at FF46: copies 160 bytes from {src,00}..{src,9F} to OAM FE00-FE9F, one byte per M-cycle.
- Blocks conflicting CPU accesses while DMA runs.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/oam_dma_bus_mem_region_decode.sv | 26 ++
 rtl/oam_dma_bus.sv | 180 ++++++++++++++++++
 tb/tb_oam_dma_bus.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: DMA state encoding, memory-map constants,
// address-region classes and the system-bus request payload.
package cpu_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT = 16'hFF46;
  localparam logic [15:0] OAM_BASE             = 16'hFE00;
  localparam logic [15:0] OAM_END              = 16'hFE9F;
  localparam logic [7:0]  HIGH_PAGE            = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    START,
    ACTIVE
  } dma_state_e;

  typedef enum logic [2:0] {
    REGION_OAM,
    REGION_UNUSABLE,
    REGION_DMA_REG,
    REGION_HIGH,
    REGION_EXTERNAL
  } mem_region_e;

  typedef struct packed {
    logic [15:0] addr;
    logic        enable;
    logic        write;
    logic [7:0]  wdata;
  } bus_req_t;

endpackage

// File: rtl/oam_dma_bus_mem_region_decode.sv
// Combinational classifier of a CPU address into memory regions.
// Ports: addr (16-bit CPU address) -> region_c (mem_region_e).
module mem_region_decode
  import cpu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT
) (
  input  logic [15:0] addr,
  output mem_region_e region_c
);

  // DMA register is checked first since it lives inside the high page.
  always_comb begin
    region_c = REGION_EXTERNAL;
    if (addr == DMA_REG_ADDR) begin
      region_c = REGION_DMA_REG;
    end else if (addr[15:8] == HIGH_PAGE) begin
      region_c = REGION_HIGH;
    end else if ((addr >= OAM_BASE) && (addr <= OAM_END)) begin
      region_c = REGION_OAM;
    end else if (addr[15:8] == OAM_BASE[15:8]) begin
      region_c = REGION_UNUSABLE;
    end
  end

endmodule

// File: rtl/oam_dma_bus.sv
// CPU system-bus router with the OAM DMA engine.
// Routes CPU accesses to the external bus or OAM, runs the FF46-triggered
// 160-byte copy into OAM (one byte per M-cycle) and blocks conflicting CPU
// accesses while the copy runs.
// Ports: clk/reset (sync, active-high); cpu_* from the CPU (cpu_rdata is
// combinational); bus_* to cartridge/WRAM/IO; oam_* to OAM; dma_active.
// Optional: define OAM_DMA_BUS_CONFLICT_EN to make blocked CPU reads return
// the byte the DMA is currently reading instead of 8'hFF.
module oam_dma_bus
  import cpu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEFAULT,
  parameter int unsigned DMA_LEN      = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        dma_active
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  logic [1:0]       t_cycle_q, t_cycle_d;
  dma_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       src_hi_q, src_hi_d;
  logic [7:0]       dma_reg_q, dma_reg_d;
  logic             keep_block_q, keep_block_d;

  mem_region_e region;
  logic        m_end;
  logic        reg_wr;
  logic        dma_active_c;
  logic [7:0]  blocked_rdata;
  bus_req_t    req;

  mem_region_decode #(
    .DMA_REG_ADDR(DMA_REG_ADDR)
  ) u_decode (
    .addr    (cpu_addr),
    .region_c(region)
  );

  assign m_end  = (t_cycle_q == 2'd3);
  assign reg_wr = cpu_enable && cpu_write && (region == REGION_DMA_REG) && m_end;

  // A restart from ACTIVE keeps the bus blocked through the setup M-cycle.
  assign dma_active_c = !reset &&
                        ((state_q == ACTIVE) || ((state_q == START) && keep_block_q));
  assign dma_active   = dma_active_c;

`ifdef OAM_DMA_BUS_CONFLICT_EN
  assign blocked_rdata = bus_rdata;
`else
  assign blocked_rdata = 8'hFF;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_cycle_q    <= 2'd0;
      state_q      <= IDLE;
      idx_q        <= '0;
      src_hi_q     <= 8'hFF;
      dma_reg_q    <= 8'hFF;
      keep_block_q <= 1'b0;
    end else begin
      t_cycle_q    <= t_cycle_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      src_hi_q     <= src_hi_d;
      dma_reg_q    <= dma_reg_d;
      keep_block_q <= keep_block_d;
    end
  end

  // Next state: everything commits at the last T-cycle of the M-cycle.
  always_comb begin
    t_cycle_d    = t_cycle_q + 2'd1;
    state_d      = state_q;
    idx_d        = idx_q;
    src_hi_d     = src_hi_q;
    dma_reg_d    = dma_reg_q;
    keep_block_d = keep_block_q;
    if (m_end) begin
      if (reg_wr) begin
        dma_reg_d    = cpu_wdata;
        // Sources at E0 and above alias down into C0-DF (echo of WRAM).
        src_hi_d     = (cpu_wdata >= 8'hE0) ? (cpu_wdata & 8'hDF) : cpu_wdata;
        idx_d        = '0;
        state_d      = START;
        keep_block_d = dma_active_c;
      end else begin
        case (state_q)
          START: begin
            state_d = ACTIVE;
            idx_d   = '0;
          end
          ACTIVE: begin
            if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output routing: DMA drives bus/OAM, CPU high-page access overrides the bus.
  always_comb begin
    req       = '0;
    oam_addr  = '0;
    oam_write = 1'b0;
    oam_wdata = '0;
    cpu_rdata = 8'hFF;
    if (!reset) begin
      if (state_q == ACTIVE) begin
        req.addr   = {src_hi_q, idx_q};
        req.enable = 1'b1;
        oam_addr   = idx_q;
        oam_wdata  = bus_rdata;
        oam_write  = m_end;
      end
      if (cpu_enable) begin
        if (region == REGION_DMA_REG) begin
          cpu_rdata = dma_reg_q;
        end else if (region == REGION_HIGH) begin
          req.addr   = cpu_addr;
          req.enable = 1'b1;
          req.write  = cpu_write;
          req.wdata  = cpu_wdata;
          cpu_rdata  = bus_rdata;
        end else if (dma_active_c) begin
          cpu_rdata = blocked_rdata;
        end else begin
          case (region)
            REGION_OAM: begin
              oam_addr  = cpu_addr[7:0];
              oam_wdata = cpu_wdata;
              oam_write = cpu_write && m_end;
              cpu_rdata = oam_rdata;
            end
            REGION_UNUSABLE: cpu_rdata = 8'h00;
            default: begin
              req.addr   = cpu_addr;
              req.enable = 1'b1;
              req.write  = cpu_write;
              req.wdata  = cpu_wdata;
              cpu_rdata  = bus_rdata;
            end
          endcase
        end
      end
    end
  end

  assign bus_addr   = req.addr;
  assign bus_enable = req.enable;
  assign bus_write  = req.write;
  assign bus_wdata  = req.wdata;

endmodule

// File: tb/tb_oam_dma_bus.sv
// Scoreboard bench for oam_dma_bus: the driver runs a per-M-cycle reference
// model of the DMA and memory map and queues expected OAM writes, bus writes
// and CPU read data; a negedge monitor pops and compares.
module tb_oam_dma_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_enable = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic        dma_active;

  oam_dma_bus dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_enable(cpu_enable),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .bus_addr  (bus_addr),
    .bus_enable(bus_enable),
    .bus_write (bus_write),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .oam_addr  (oam_addr),
    .oam_write (oam_write),
    .oam_wdata (oam_wdata),
    .oam_rdata (oam_rdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // External bus and OAM device models.
  logic [7:0] mix = 8'h00;
  logic [7:0] oam_mem [256];
  assign bus_rdata = bus_addr[7:0] ^ 8'h5A ^ (bus_addr[15:8] & mix);
  assign oam_rdata = oam_mem[oam_addr];
  always @(posedge clk) if (oam_write) oam_mem[oam_addr] <= oam_wdata;

  function automatic logic [7:0] busfn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] & mix);
  endfunction

  typedef struct packed {
    logic [7:0]  d;
    logic        chk;
    logic [15:0] ba;
  } rd_exp_t;

  logic [15:0] exp_oam [$];
  logic [23:0] exp_bw [$];
  rd_exp_t     exp_rd [$];

  int     n_cmp = 0;
  int     n_fail = 0;
  int     cur_t = 5;
  bit     exp_active = 1'b0;
  longint cyc = 0;
  longint trig_cyc = 0;
  bit     chk_len = 1'b0;
  bit     prev_active = 1'b0;

  // Reference model state, one step per M-cycle.
  logic [7:0] m_reg = 8'hFF;
  logic [7:0] m_src = 8'hFF;
  bit         m_on = 1'b0;
  bit         m_setup = 1'b0;
  bit         m_restart = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_oam [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor.
  always @(negedge clk) begin
    logic [15:0] eo;
    logic [23:0] eb;
    rd_exp_t     er;
    chk("dma_active", 32'(dma_active), 32'(exp_active));
    if (chk_len && prev_active && !dma_active) begin
      chk("dma_len_clk", 32'(cyc - trig_cyc), 32'd644);
      chk_len = 1'b0;
    end
    prev_active = dma_active;
    if (oam_write || (cur_t == 3 && exp_oam.size() != 0)) begin
      if (exp_oam.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL oam_write_unexpected: got addr %h data %h expected none", oam_addr, oam_wdata);
      end else begin
        eo = exp_oam.pop_front();
        chk("oam_write", {15'd0, oam_write, oam_addr, oam_wdata}, {15'd0, 1'b1, eo});
      end
    end
    if (cur_t == 3) begin
      if (bus_write || exp_bw.size() != 0) begin
        if (exp_bw.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL bus_write_unexpected: got addr %h data %h expected none", bus_addr, bus_wdata);
        end else begin
          eb = exp_bw.pop_front();
          chk("bus_write", {7'd0, bus_write, bus_addr, bus_wdata}, {7'd0, 1'b1, eb});
        end
      end
      if (exp_rd.size() != 0) begin
        er = exp_rd.pop_front();
        chk("cpu_rdata", 32'(cpu_rdata), 32'(er.d));
        if (er.chk) chk("bus_addr", 32'(bus_addr), 32'(er.ba));
      end
    end
  end

  function automatic void push_rd(input logic [7:0] d, input logic c, input logic [15:0] ba);
    rd_exp_t r;
    r.d = d; r.chk = c; r.ba = ba;
    exp_rd.push_back(r);
  endfunction

  // One CPU M-cycle plus the model's expectations for it.
  task automatic mcyc(input bit en, input bit we, input logic [15:0] a, input logic [7:0] d);
    bit          xfer, blk, fire;
    logic [15:0] dma_a, eff_a;
    logic [7:0]  v;
    xfer  = m_on && !m_setup;
    blk   = xfer || (m_on && m_setup && m_restart);
    dma_a = xfer ? {m_src, 8'(m_pos)} : 16'h0000;
    eff_a = dma_a;
    if (en && a[15:8] == 8'hFF && a != 16'hFF46) eff_a = a;
    fire = 1'b0;
    if (xfer) begin
      v = busfn(eff_a);
      exp_oam.push_back({8'(m_pos), v});
      m_oam[m_pos] = v;
    end
    if (en) begin
      if (a == 16'hFF46) begin
        if (we) fire = 1'b1; else push_rd(m_reg, 1'b0, 16'h0);
      end else if (a[15:8] == 8'hFF) begin
        if (we) exp_bw.push_back({a, d}); else push_rd(busfn(a), 1'b1, a);
      end else if (blk) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
        if (!we) push_rd(busfn(dma_a), 1'b0, 16'h0);
`else
        if (!we) push_rd(8'hFF, 1'b0, 16'h0);
`endif
      end else if (a >= 16'hFE00 && a <= 16'hFE9F) begin
        if (we) begin
          exp_oam.push_back({a[7:0], d});
          m_oam[a[7:0]] = d;
        end else push_rd(m_oam[a[7:0]], 1'b0, 16'h0);
      end else if (a >= 16'hFEA0 && a <= 16'hFEFF) begin
        if (!we) push_rd(8'h00, 1'b0, 16'h0);
      end else begin
        if (we) exp_bw.push_back({a, d}); else push_rd(busfn(a), 1'b1, a);
      end
    end
    exp_active = blk;
    cpu_enable = en; cpu_write = we; cpu_addr = a; cpu_wdata = d;
    for (int t = 0; t < 4; t++) begin
      cur_t = t;
      @(posedge clk);
      #1;
    end
    if (fire) begin
      m_reg     = d;
      m_src     = (d >= 8'hE0) ? (d & 8'hDF) : d;
      m_restart = blk;
      m_on      = 1'b1;
      m_setup   = 1'b1;
      m_pos     = 0;
    end else if (m_on && m_setup) begin
      m_setup = 1'b0;
      m_pos   = 0;
    end else if (xfer) begin
      m_pos++;
      if (m_pos == 160) m_on = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_enable = 1'b0; cpu_write = 1'b0;
    cur_t = 5; exp_active = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reg = 8'hFF; m_src = 8'hFF; m_on = 1'b0; m_setup = 1'b0; m_restart = 1'b0; m_pos = 0;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
      1: return 16'hFE00 + 16'($urandom_range(0, 159));
      2: return 16'hFEA0 + 16'($urandom_range(0, 95));
      3: return 16'hFF80 + 16'($urandom_range(0, 126));
      4: return 16'($urandom_range(0, 16'h7FFF));
      default: return 16'hFF00 + 16'($urandom_range(0, 16'h46));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      oam_mem[i] = 8'h00;
      m_oam[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle routing and reset value of the DMA register.
    mcyc(1, 1, 16'hFE10, 8'h3C);
    mcyc(1, 0, 16'hFEA5, 8'h00);
    mcyc(1, 0, 16'hFF46, 8'h00);
    mcyc(1, 0, 16'hFE10, 8'h00);
    mcyc(1, 0, 16'hC123, 8'h00);

    // Full transfer from C100 with blocked and high-page accesses mid-copy.
    mcyc(1, 1, 16'hFF46, 8'hC1);
    trig_cyc = cyc;
    chk_len  = 1'b1;
    while (m_on) begin
      if (!m_setup && m_pos == 5)      mcyc(1, 0, 16'hC000, 8'h00);
      else if (!m_setup && m_pos == 6) mcyc(1, 1, 16'hC000, 8'h77);
      else if (!m_setup && m_pos == 7) mcyc(1, 0, 16'hFF80, 8'h00);
      else if (!m_setup && m_pos == 8) mcyc(1, 1, 16'hFE20, 8'h11);
      else                             mcyc(0, 0, 16'h0000, 8'h00);
    end
    repeat (2) mcyc(0, 0, 16'h0000, 8'h00);

    // Restart at index 50 with a new source.
    mix = 8'hFF;
    mcyc(1, 1, 16'hFF46, 8'hC1);
    while (!(m_on && !m_setup && m_pos == 50)) mcyc(0, 0, 16'h0000, 8'h00);
    mcyc(1, 1, 16'hFF46, 8'hD0);
    mcyc(1, 0, 16'hFF46, 8'h00);
    while (m_on) mcyc(0, 0, 16'h0000, 8'h00);

    // Source above DF is masked; register reads back unmasked.
    mcyc(1, 1, 16'hFF46, 8'hFE);
    mcyc(1, 0, 16'hFF46, 8'h00);
    while (m_on) mcyc(1, 0, 16'hD000, 8'h00);

    // Reset in the middle of a transfer.
    mcyc(1, 1, 16'hFF46, 8'h12);
    while (!(m_on && !m_setup && m_pos == 80)) mcyc(0, 0, 16'h0000, 8'h00);
    do_reset();
    mcyc(1, 0, 16'hFF46, 8'h00);
    repeat (10) mcyc(0, 0, 16'h0000, 8'h00);
    mcyc(1, 0, 16'hC000, 8'h00);

    // Randomized traffic with occasional DMA triggers.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 199) == 0)    mcyc(1, 1, 16'hFF46, 8'($urandom));
      else if ($urandom_range(0, 3) == 0) mcyc(0, 0, 16'h0000, 8'h00);
      else mcyc(1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    end
    while (m_on) mcyc(0, 0, 16'h0000, 8'h00);
    repeat (2) mcyc(0, 0, 16'h0000, 8'h00);
    cur_t = 5;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
